// File: rtl/io_pkg.sv
// Shared definitions for the front-panel hex I/O: keypad FSM state encodings,
// keypad idle/initial patterns and the hex digit width.
package io_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_SCAN   = 2'd0;
  localparam logic [1:0] ST_DEB    = 2'd1;
  localparam logic [1:0] ST_ACCEPT = 2'd2;
  localparam logic [1:0] ST_REL    = 2'd3;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'hF;

  // Advance the active-low row strobe to the next row (1110->1101->1011->0111).
  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: counts 0..N-1 and pulses tick for one clk on the last count.
module scan_tick #(
  parameter int N = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  // Wrap the counter after the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with per-key debounce and a 4-digit hex entry
// shift register. Optional macro KEYPAD_SYNC_EN inserts a 2-flop synchronizer
// on col for keypads asynchronous to clk (adds 2 clk of input latency).
module keypad_scan #(
  parameter int SCAN_DIV = 10000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [15:0] num,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  import io_pkg::*;

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  logic       tick;
  logic [3:0] col_s;

  logic [1:0]           state_reg, state_next;
  logic [3:0]           row_reg, row_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [3:0]           cand_reg, cand_next;
  logic [4*DIGIT_W-1:0] num_reg, num_next;
  logic [3:0]           key_code_reg, key_code_next;
  logic                 key_valid_reg, key_valid_next;

  scan_tick #(.N(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_reg, sync2_reg;

  // Two-stage synchronizer; idles high so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= COL_IDLE;
      sync2_reg <= COL_IDLE;
    end else begin
      sync1_reg <= col;
      sync2_reg <= sync1_reg;
    end
  end

  assign col_s = sync2_reg;
`else
  assign col_s = col;
`endif

  // Priority encoder: high_below[i] says every column below i is released,
  // so first_low is one-hot on the lowest pressed column.
  logic [4:0] high_below;
  logic [3:0] first_low;
  assign high_below[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_prio
      assign first_low[gi]      = ~col_s[gi] & high_below[gi];
      assign high_below[gi + 1] = high_below[gi] & col_s[gi];
    end
  endgenerate

  logic       hit;
  logic [1:0] col_idx, row_idx;
  logic [3:0] code, cnt_inc;

  assign hit     = (col_s != COL_IDLE);
  assign code    = {row_idx, col_idx};
  assign cnt_inc = cnt_reg + 4'd1;

  // Convert the one-hot column and the row strobe into 2-bit indices.
  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (first_low[i]) col_idx = 2'(i);
    end
    case (row_reg)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Scan/debounce/accept/release state machine; all but ACCEPT wait for tick.
  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    cnt_next       = cnt_reg;
    cand_next      = cand_reg;
    num_next       = num_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    case (state_reg)
      ST_SCAN: begin
        if (tick) begin
          if (!hit) begin
            row_next = rotl4(row_reg);
          end else begin
            cand_next  = code;
            cnt_next   = 4'd1;
            state_next = (DEBOUNCE == 1) ? ST_ACCEPT : ST_DEB;
          end
        end
      end
      ST_DEB: begin
        if (tick) begin
          if (hit && (code == cand_reg)) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DEB_N) state_next = ST_ACCEPT;
          end else begin
            cnt_next   = 4'd0;
            row_next   = rotl4(row_reg);
            state_next = ST_SCAN;
          end
        end
      end
      ST_ACCEPT: begin
        key_valid_next = 1'b1;
        key_code_next  = cand_reg;
        num_next       = {num_reg[4*DIGIT_W-5:0], cand_reg};
        cnt_next       = 4'd0;
        state_next     = ST_REL;
      end
      default: begin
        if (tick) begin
          cnt_next = hit ? 4'd0 : cnt_inc;
          if (!hit && (cnt_inc == DEB_N)) begin
            cnt_next   = 4'd0;
            row_next   = rotl4(row_reg);
            state_next = ST_SCAN;
          end
        end
      end
    endcase
    // Clear overrides any shift happening in the same cycle.
    if (clr) num_next = '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_SCAN;
      row_reg       <= ROW_INIT;
      cnt_reg       <= 4'd0;
      cand_reg      <= 4'd0;
      num_reg       <= '0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      cnt_reg       <= cnt_next;
      cand_reg      <= cand_next;
      num_reg       <= num_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
    end
  end

  assign row       = row_reg;
  assign num       = num_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key-matrix model.
module tb_keypad_scan;
  import io_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] num;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c held down
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [3:0]  last_code = 4'd0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .clr       (clr),
    .row       (row),
    .num       (num),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4 + c]) col[c] = 1'b0;
      end
    end
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (key_valid) begin
      pulses    <= pulses + 1;
      last_code <= key_code;
    end
  end

  typedef struct {
    logic        do_clr;
    logic [15:0] k;
    logic [15:0] exp_num;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_run(input logic [15:0] k, input int hold, input int idle);
    keys = k;
    cyc(hold);
    keys = '0;
    cyc(idle);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int n = 0;
    while (dut.state_reg !== st && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, n < 200}, 32'd1);
  endtask

  initial begin
    int         p0;
    logic [3:0] exp_row;

    vecs[0] = '{1'b1, 16'h0002, 16'h0001, 4'h1};
    vecs[1] = '{1'b0, 16'h0004, 16'h0012, 4'h2};
    vecs[2] = '{1'b0, 16'h0008, 16'h0123, 4'h3};
    vecs[3] = '{1'b0, 16'h0010, 16'h1234, 4'h4};
    vecs[4] = '{1'b0, 16'h0020, 16'h2345, 4'h5};

    // Reset held 3 clk, then idle scanning rotates the row every 4 clk.
    cyc(3);
    chk("rst_row", {28'd0, row}, {28'd0, ROW_INIT});
    chk("rst_num", {16'd0, num}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp_row = ROW_INIT;
      for (int j = 0; j < k / 4; j++) exp_row = {exp_row[2:0], exp_row[3]};
      chk($sformatf("scan_row_%0d", k), {28'd0, row}, {28'd0, exp_row});
    end

    // Key 9 held 40 clk; row stays on row 2 until release is debounced.
    p0   = pulses;
    keys = 16'h0200;
    cyc(40);
    chk("k9_row_held", {28'd0, row}, 32'b1011);
    keys = '0;
    cyc(3);
    chk("k9_row_rel", {28'd0, row}, 32'b1011);
    cyc(37);
    chk("k9_pulses", pulses - p0, 32'd1);
    chk("k9_code", {28'd0, last_code}, 32'h9);
    chk("k9_num", {16'd0, num}, 32'h0009);

    // Keys 1..5 in sequence after a clear.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_clr) pulse_clr();
      p0 = pulses;
      key_run(vecs[i].k, 40, 40);
      chk($sformatf("seq%0d_pulses", i), pulses - p0, 32'd1);
      chk($sformatf("seq%0d_code", i), {28'd0, last_code}, {28'd0, vecs[i].exp_code});
      chk($sformatf("seq%0d_num", i), {16'd0, num}, {16'd0, vecs[i].exp_num});
    end

    // Keys 4 and 7 together: lowest column wins; 7 alone is ignored until full release.
    p0   = pulses;
    keys = 16'h0090;
    cyc(40);
    keys = 16'h0080;
    cyc(40);
    chk("k47_held_pulses", pulses - p0, 32'd1);
    keys = '0;
    cyc(40);
    chk("k47_pulses", pulses - p0, 32'd1);
    chk("k47_code", {28'd0, last_code}, 32'h4);
    chk("k47_num", {16'd0, num}, 32'h3454);

    // Key 6 bouncing every tick for 20 clk, then steady.
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      cyc(4);
    end
    key_run(16'h0040, 40, 40);
    chk("bounce_pulses", pulses - p0, 32'd1);
    chk("bounce_code", {28'd0, last_code}, 32'h6);
    chk("bounce_num", {16'd0, num}, 32'h4546);

    // Build num=0x00FF, then clear exactly on the ACCEPT cycle of key A.
    pulse_clr();
    key_run(16'h8000, 40, 40);
    key_run(16'h8000, 40, 40);
    chk("ff_num", {16'd0, num}, 32'h00FF);
    keys = 16'h0400;
    wait_state(ST_ACCEPT, "wait_accept");
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_acc_num", {16'd0, num}, 32'h0);
    chk("clr_acc_code", {28'd0, key_code}, 32'hA);
    chk("clr_acc_valid", {31'd0, key_valid}, 32'd1);
    keys = '0;
    cyc(40);

    // Reset during DEB returns every output to its reset value.
    key_run(16'h0020, 40, 40);
    chk("pre_rst_num", {16'd0, num}, 32'h0005);
    keys = 16'h0008;
    wait_state(ST_DEB, "wait_deb");
    rst = 1'b1;
    cyc(1);
    chk("deb_rst_row", {28'd0, row}, {28'd0, ROW_INIT});
    chk("deb_rst_num", {16'd0, num}, 32'h0);
    chk("deb_rst_code", {28'd0, key_code}, 32'h0);
    chk("deb_rst_valid", {31'd0, key_valid}, 32'd0);
    rst = 1'b0;
    p0 = pulses;
    cyc(40);
    keys = '0;
    cyc(40);
    chk("redetect_pulses", pulses - p0, 32'd1);
    chk("redetect_num", {16'd0, num}, 32'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
